// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, 3-sample majority voting,
// sticky error flags and a ready/valid output FIFO.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 435,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overflow,
  input  logic                 err_clr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] MID    = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] MID_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] MID_P1 = CNT_W'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic             ODD_MODE  = (PARITY == 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic                 r_rx_prev;
  logic [1:0]           r_init;
  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_baud;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_bad;
  logic                 r_v0;
  logic                 r_v1;

  logic                 w_vote;
  logic                 w_resolve;
  logic                 w_last_stop;
  logic                 w_push;
  logic                 w_set_perr;
  logic                 w_set_ferr;

  // r_rx_prev only reports a high line once the synchroniser holds real samples,
  // so a line already low when reset releases never looks like a start edge.
  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b0;
      r_init    <= 2'b00;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_init    <= {r_init[0], 1'b1};
      r_rx_prev <= r_rx_s & r_init[1];
    end
  end

  assign w_vote      = majority(r_v0, r_v1, r_rx_s);
  assign w_resolve   = (r_baud == MID_P1);
  assign w_last_stop = (r_bit_cnt == STOP_LAST);
  assign w_push      = (r_state == S_STOP) && w_resolve && w_vote && w_last_stop && !r_bad;
  assign w_set_perr  = (r_state == S_STOP) && w_resolve && w_vote && w_last_stop && r_bad;
  assign w_set_ferr  = (r_state == S_STOP) && w_resolve && !w_vote;

  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_bad     <= 1'b0;
      r_v0      <= 1'b1;
      r_v1      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud    <= '0;
          r_bit_cnt <= '0;
          r_bad     <= 1'b0;
          if (r_rx_prev && !r_rx_s) r_state <= S_START;
        end
        S_BREAK: begin
          r_baud <= '0;
          if (r_rx_s) r_state <= S_IDLE;
        end
        default: begin
          r_baud <= (r_baud == LAST) ? '0 : r_baud + 1'b1;
          if (r_baud == MID_M1) r_v0 <= r_rx_s;
          if (r_baud == MID)    r_v1 <= r_rx_s;
          // State changes happen at the resolve point; the following bit's
          // votes only come at its own mid-point, after the counter wraps.
          if (w_resolve) begin
            case (r_state)
              S_START: r_state <= w_vote ? S_IDLE : S_DATA;
              S_DATA: begin
                r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                if (r_bit_cnt == DATA_LAST) begin
                  r_bit_cnt <= '0;
                  r_state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                end else begin
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                end
              end
              S_PARITY: begin
                if ((^r_shift ^ w_vote) != ODD_MODE) r_bad <= 1'b1;
                r_state <= S_STOP;
              end
              S_STOP: begin
                if (!w_vote) begin
                  r_state <= S_BREAK;
                end else if (w_last_stop) begin
                  r_state <= S_IDLE;
                  r_baud  <= '0;
                end else begin
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                end
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W:0]       r_count;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr;
  logic                 w_ovf;

  assign w_full   = (r_count == DEPTH_CNT);
  assign rd_valid = (r_count != '0);
  assign rd_data  = r_mem[r_rd_ptr];
  assign w_pop    = rd_valid & rd_ready;
  assign w_wr     = w_push & (!w_full | w_pop);
  assign w_ovf    = w_push & w_full & !w_pop;

  // When full, a simultaneous pop frees the head slot that the write lands in.
  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  logic r_perr;
  logic r_ferr;
  logic r_ovf;

  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_perr <= w_set_perr | (r_perr & ~err_clr);
      r_ferr <= w_set_ferr | (r_ferr & ~err_clr);
      r_ovf  <= w_ovf      | (r_ovf  & ~err_clr);
    end
  end

  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: instance A uses 8N1, instance B uses
// 7 data bits, even parity and two stop bits.
module tb_uart_rx_fifo;

  localparam int CPB = 16;
  localparam int M   = CPB / 2;

  logic       clk = 1'b0;
  logic       nrst;
  logic       rx_a, rx_b;
  logic       rdy_a, rdy_b;
  logic       clr_a, clr_b;
  logic [7:0] rd_data_a;
  logic [6:0] rd_data_b;
  logic       vld_a, vld_b;
  logic       perr_a, ferr_a, ovf_a;
  logic       perr_b, ferr_b, ovf_b;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB)) u_a (
    .clk(clk), .nRst(nrst), .rx(rx_a), .rd_data(rd_data_a), .rd_valid(vld_a),
    .rd_ready(rdy_a), .parity_err(perr_a), .frame_err(ferr_a), .overflow(ovf_a),
    .err_clr(clr_a));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .nRst(nrst), .rx(rx_b), .rd_data(rd_data_b), .rd_valid(vld_b),
    .rd_ready(rdy_b), .parity_err(perr_b), .frame_err(ferr_b), .overflow(ovf_b),
    .err_clr(clr_b));

  int total = 0;
  int bad   = 0;
  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  bit exp_perr[2];
  bit exp_ferr[2];
  bit exp_ovf[2];
  int occ_a;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitors: compare each word the consumer accepts against the scoreboard.
  always @(negedge clk) begin
    #2;
    if (vld_a === 1'b1 && rdy_a === 1'b1) begin
      if (q_a.size() == 0) check("a_unexpected_word", {24'd0, rd_data_a}, 32'hFFFF_FFFF);
      else check("a_word", {24'd0, rd_data_a}, {23'd0, q_a.pop_front()});
    end
  end

  always @(negedge clk) begin
    #2;
    if (vld_b === 1'b1 && rdy_b === 1'b1) begin
      if (q_b.size() == 0) check("b_unexpected_word", {25'd0, rd_data_b}, 32'hFFFF_FFFF);
      else check("b_word", {25'd0, rd_data_b}, {23'd0, q_b.pop_front()});
    end
  end

  // Reference: outcome of one frame from its content alone.
  // 0 = word delivered, 1 = parity error, 2 = framing error.
  function automatic int model(input int nbits, input int pmode, input logic [8:0] d,
                               input logic pbit, input logic stop_ok);
    logic [8:0] mask;
    int ones;
    mask = 9'((1 << nbits) - 1);
    ones = $countones(d & mask) + int'(pbit);
    if (!stop_ok) return 2;
    if (pmode == 1 && (ones % 2) == 0) return 1;
    if (pmode == 2 && (ones % 2) == 1) return 1;
    return 0;
  endfunction

  task automatic drive(input int line, input logic v);
    if (line == 0) rx_a = v; else rx_b = v;
  endtask

  task automatic hold_bit(input int line, input logic v, input bit glitch);
    for (int c = 0; c < CPB; c++) begin
      drive(line, (glitch && c == M) ? ~v : v);
      @(negedge clk);
    end
    drive(line, v);
  endtask

  task automatic send_frame(input int line, input int nbits, input logic [8:0] d,
                            input int pmode, input logic pbit, input int nstops,
                            input logic stop_ok, input int glitch);
    hold_bit(line, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) hold_bit(line, d[i], (i == glitch));
    if (pmode != 0) hold_bit(line, pbit, 1'b0);
    for (int s = 0; s < nstops; s++) hold_bit(line, (s == nstops - 1) ? stop_ok : 1'b1, 1'b0);
    if (!stop_ok) hold_bit(line, 1'b1, 1'b0);
    drive(line, 1'b1);
  endtask

  task automatic tx(input int line, input logic [8:0] d, input logic pbit,
                    input logic stop_ok, input int glitch);
    int nb, pm, ns, res;
    logic [8:0] dm;
    nb = (line == 0) ? 8 : 7;
    pm = (line == 0) ? 0 : 2;
    ns = (line == 0) ? 1 : 2;
    dm = d & 9'((1 << nb) - 1);
    res = model(nb, pm, dm, pbit, stop_ok);
    if (res == 1) exp_perr[line] = 1'b1;
    else if (res == 2) exp_ferr[line] = 1'b1;
    else if (line == 1) q_b.push_back(dm);
    else if (rdy_a) q_a.push_back(dm);
    else if (occ_a == 4) exp_ovf[0] = 1'b1;
    else begin
      occ_a++;
      q_a.push_back(dm);
    end
    send_frame(line, nb, dm, pm, pbit, ns, stop_ok, glitch);
  endtask

  task automatic drain(input int line);
    int n;
    n = 0;
    while (((line == 0) ? q_a.size() : q_b.size()) != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check((line == 0) ? "a_drain_left" : "b_drain_left",
          (line == 0) ? q_a.size() : q_b.size(), 0);
    occ_a = (line == 0) ? 0 : occ_a;
  endtask

  task automatic check_flags(input int line, input string tag);
    if (line == 0) begin
      check({tag, "_perr"}, {31'd0, perr_a}, {31'd0, exp_perr[0]});
      check({tag, "_ferr"}, {31'd0, ferr_a}, {31'd0, exp_ferr[0]});
      check({tag, "_ovf"},  {31'd0, ovf_a},  {31'd0, exp_ovf[0]});
    end else begin
      check({tag, "_perr"}, {31'd0, perr_b}, {31'd0, exp_perr[1]});
      check({tag, "_ferr"}, {31'd0, ferr_b}, {31'd0, exp_ferr[1]});
      check({tag, "_ovf"},  {31'd0, ovf_b},  {31'd0, exp_ovf[1]});
    end
  endtask

  task automatic pulse_clr(input int line);
    if (line == 0) clr_a = 1'b1; else clr_b = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    clr_b = 1'b0;
    exp_perr[line] = 1'b0;
    exp_ferr[line] = 1'b0;
    exp_ovf[line]  = 1'b0;
    @(negedge clk);
  endtask

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    occ_a = 0;
    for (int l = 0; l < 2; l++) begin
      exp_perr[l] = 1'b0;
      exp_ferr[l] = 1'b0;
      exp_ovf[l]  = 1'b0;
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_valid"}, {31'd0, vld_a}, 0);
    check({tag, "_data"},  {24'd0, rd_data_a}, 0);
    check_flags(0, tag);
  endtask

  initial begin
    logic [7:0] d;
    logic [6:0] d7;
    logic pb;
    nrst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    rdy_a = 1'b0; rdy_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    check_reset_a("rst_a");
    check("rst_b_valid", {31'd0, vld_b}, 0);
    check("rst_b_data", {25'd0, rd_data_b}, 0);
    check_flags(1, "rst_b");
    nrst = 1'b0;
    repeat (5) @(negedge clk);

    // Back-to-back 8N1 frames with an always-ready consumer.
    rdy_a = 1'b1;
    tx(0, 9'hAA, 1'b0, 1'b1, -1);
    tx(0, 9'hAD, 1'b0, 1'b1, -1);
    tx(0, 9'h01, 1'b0, 1'b1, -1);
    tx(0, 9'h00, 1'b0, 1'b1, -1);
    tx(0, 9'hAA, 1'b0, 1'b1, -1);
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      tx(0, {1'b0, d}, 1'b0, 1'b1, -1);
    end
    drain(0);
    check_flags(0, "b2b");

    // Stalled consumer: the fifth and sixth words overflow the four-deep FIFO.
    rdy_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tx(0, 9'(8'h11 + i), 1'b0, 1'b1, -1);
      if (i == 3) check("ovf_after4", {31'd0, ovf_a}, {31'd0, exp_ovf[0]});
      if (i == 4) check("ovf_after5", {31'd0, ovf_a}, {31'd0, exp_ovf[0]});
    end
    repeat (20) @(negedge clk);
    check("stall_head_held", {24'd0, rd_data_a}, 32'h11);
    check("stall_valid", {31'd0, vld_a}, 1);
    rdy_a = 1'b1;
    drain(0);
    check_flags(0, "ovf");
    pulse_clr(0);
    check_flags(0, "ovf_clr");

    // Even parity, 7 data bits, 2 stop bits.
    rdy_b = 1'b1;
    tx(1, 9'h55, 1'b0, 1'b1, -1);
    drain(1);
    check_flags(1, "par_good");
    tx(1, 9'h55, 1'b1, 1'b1, -1);
    repeat (4) @(negedge clk);
    check_flags(1, "par_bad");
    check("par_bad_no_push", {31'd0, vld_b}, 0);
    pulse_clr(1);
    for (int i = 0; i < 8; i++) begin
      d7 = 7'($urandom_range(0, 127));
      pb = ^d7;
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      tx(1, {2'b0, d7}, pb, ($urandom_range(0, 5) != 0), -1);
    end
    drain(1);
    check_flags(1, "b_rand");
    pulse_clr(1);

    // Break: line held low for 12 bit times.
    rx_a = 1'b0;
    exp_ferr[0] = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_flags(0, "break");
    check("break_no_push", {31'd0, vld_a}, 0);
    tx(0, 9'h3C, 1'b0, 1'b1, -1);
    drain(0);
    pulse_clr(0);
    check_flags(0, "break_clr");

    // Short low glitch on an idle line, then glitched data bits.
    rx_a = 1'b0;
    repeat (M / 2) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_no_push", {31'd0, vld_a}, 0);
    check_flags(0, "glitch");
    tx(0, 9'h5A, 1'b0, 1'b1, 3);
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      tx(0, {1'b0, d}, 1'b0, 1'b1, int'($urandom_range(0, 7)));
    end
    drain(0);

    // Reset during bit 4 of 0xF0 with a word waiting in the FIFO.
    rdy_a = 1'b0;
    tx(0, 9'h77, 1'b0, 1'b1, -1);
    repeat (4) @(negedge clk);
    check("pre_rst_valid", {31'd0, vld_a}, 1);
    check("pre_rst_data", {24'd0, rd_data_a}, 32'h77);
    hold_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) hold_bit(0, 1'b0, 1'b0);
    rx_a = 1'b1;
    repeat (M) @(negedge clk);
    nrst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_a("midrst");
    nrst = 1'b0;
    repeat (6 * CPB) @(negedge clk);
    check("midrst_after", {31'd0, vld_a}, 0);
    rdy_a = 1'b1;
    tx(0, 9'h0F, 1'b0, 1'b1, -1);
    drain(0);
    check_flags(0, "midrst_rx");

    // Line already low when reset releases must not start a frame.
    nrst = 1'b1;
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("lowrel_no_push", {31'd0, vld_a}, 0);
    check_flags(0, "lowrel");
    d = 8'($urandom_range(0, 255));
    tx(0, {1'b0, d}, 1'b0, 1'b1, -1);
    drain(0);

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
